// File: rtl/reg_bank_if.sv
// Bus between the decoder/ALU side and the register bank.
// Clock and reset are plain ports on the bank, not part of this bundle.
interface reg_bank_if #(
  parameter int WIDTH    = 4,
  parameter int NREG     = 4,
  parameter int PC_WIDTH = 4,
  parameter int SELW     = $clog2(NREG)
);
  logic                     EN;
  logic [NREG-1:0]          LOAD;
  logic [WIDTH-1:0]         Im;
  logic [SELW-1:0]          RSEL;
  logic [WIDTH-1:0]         RData;
  logic [NREG*WIDTH-1:0]    Regs;
  logic                     PC_LOAD;
  logic [PC_WIDTH-1:0]      PC_Im;
  logic [PC_WIDTH-1:0]      PC;
  logic                     FLAG_WE;
  logic                     Carry;
  logic                     CFlag;
  logic                     ZFlag;
  logic                     Wrap;

  // Decoder/ALU side: drives strobes and data, observes state.
  modport master (
    output EN, LOAD, Im, RSEL, PC_LOAD, PC_Im, FLAG_WE, Carry,
    input  RData, Regs, PC, CFlag, ZFlag, Wrap
  );

  // Register bank side.
  modport slave (
    input  EN, LOAD, Im, RSEL, PC_LOAD, PC_Im, FLAG_WE, Carry,
    output RData, Regs, PC, CFlag, ZFlag, Wrap
  );
endinterface

// File: rtl/reg_bank.sv
// TD4-class register bank: NREG GP registers, program counter with
// jump/increment and rollover pulse, clocked carry/zero flags.
// Priority on every edge: CLR, then EN, then normal update.
module reg_bank #(
  parameter int                  WIDTH    = 4,
  parameter int                  NREG     = 4,
  parameter int                  PC_WIDTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic       CLK,
  input logic       CLR,
  reg_bank_if.slave bus
);

  logic [WIDTH-1:0]    regs [NREG];
  logic [PC_WIDTH-1:0] pc;
  logic                cflag;
  logic                zflag;
  logic                wrap;
  logic [WIDTH-1:0]    rdata;

  // GP registers: each active-low strobe loads the shared write data.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.EN) begin
      for (int i = 0; i < NREG; i++) begin
        if (!bus.LOAD[i]) regs[i] <= bus.Im;
      end
    end
  end

  // Program counter: jump on low PC_LOAD, otherwise always increment
  // while enabled; Wrap flags only an increment-driven rollover.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      pc   <= RESET_PC;
      wrap <= 1'b0;
    end else if (bus.EN) begin
      if (!bus.PC_LOAD) begin
        pc   <= bus.PC_Im;
        wrap <= 1'b0;
      end else begin
        pc   <= pc + 1'b1;
        wrap <= (pc == '1);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  // Flags: captured from the ALU only when enabled and FLAG_WE is high.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      cflag <= 1'b0;
      zflag <= 1'b0;
    end else if (bus.EN && bus.FLAG_WE) begin
      cflag <= bus.Carry;
      zflag <= (bus.Im == '0);
    end
  end

  // Read port: out-of-range selects return zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(bus.RSEL) == i) rdata = regs[i];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign bus.Regs[g*WIDTH +: WIDTH] = regs[g];
  end

  assign bus.RData = rdata;
  assign bus.PC    = pc;
  assign bus.CFlag = cflag;
  assign bus.ZFlag = zflag;
  assign bus.Wrap  = wrap;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default 4x4 instance plus an 8x8 / 6-bit PC
// instance with a non-zero reset PC.
module tb_reg_bank;

  logic CLK = 1'b0;
  logic CLR;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  reg_bank_if #(.WIDTH(4), .NREG(4), .PC_WIDTH(4)) a ();
  reg_bank_if #(.WIDTH(8), .NREG(8), .PC_WIDTH(6)) b ();

  reg_bank #(.WIDTH(4), .NREG(4), .PC_WIDTH(4), .RESET_PC(4'h0)) dut_a (
    .CLK (CLK),
    .CLR (CLR),
    .bus (a.slave)
  );

  reg_bank #(.WIDTH(8), .NREG(8), .PC_WIDTH(6), .RESET_PC(6'h20)) dut_b (
    .CLK (CLK),
    .CLR (CLR),
    .bus (b.slave)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Initial reset of both instances
    CLR = 1'b1;
    a.EN = 1'b1; a.LOAD = 4'hF; a.Im = 4'h0; a.RSEL = 2'd0;
    a.PC_LOAD = 1'b1; a.PC_Im = 4'h0; a.FLAG_WE = 1'b0; a.Carry = 1'b0;
    b.EN = 1'b1; b.LOAD = 8'hFF; b.Im = 8'h00; b.RSEL = 3'd0;
    b.PC_LOAD = 1'b1; b.PC_Im = 6'h00; b.FLAG_WE = 1'b0; b.Carry = 1'b0;
    tick();
    chk("rst_regs", 64'(a.Regs), 64'h0);
    chk("rst_pc", 64'(a.PC), 64'h0);
    chk("rst_rdata", 64'(a.RData), 64'h0);
    chk("rst_flags", 64'({a.CFlag, a.ZFlag, a.Wrap}), 64'h0);
    chk("b_rst_pc", 64'(b.PC), 64'h20);
    b.EN = 1'b0;

    // Arbitrary state, then mid-operation reset with all strobes active
    CLR = 1'b0;
    a.LOAD = 4'h0; a.Im = 4'h9; a.PC_LOAD = 1'b0; a.PC_Im = 4'h7;
    a.FLAG_WE = 1'b1; a.Carry = 1'b1;
    tick();
    chk("arb_regs", 64'(a.Regs), 64'h9999);
    chk("arb_pc", 64'(a.PC), 64'h7);
    chk("arb_flags", 64'({a.CFlag, a.ZFlag}), 64'b10);
    CLR = 1'b1;
    tick();
    chk("mid_rst_regs", 64'(a.Regs), 64'h0);
    chk("mid_rst_pc", 64'(a.PC), 64'h0);
    chk("mid_rst_flags", 64'({a.CFlag, a.ZFlag, a.Wrap}), 64'h0);

    // First enabled edge after reset increments from RESET_PC
    CLR = 1'b0;
    a.FLAG_WE = 1'b0; a.PC_LOAD = 1'b1;
    a.LOAD = 4'b1011; a.Im = 4'h5;
    tick();
    chk("pc_after_rst", 64'(a.PC), 64'h1);
    chk("load_reg2", 64'(a.Regs), 64'h0500);

    // Load reg1, RData shows old value until the edge
    a.LOAD = 4'b1101; a.Im = 4'hA; a.RSEL = 2'd1;
    #1;
    chk("no_write_through", 64'(a.RData), 64'h0);
    tick();
    chk("load_reg1", 64'(a.Regs), 64'h05A0);
    chk("rdata_reg1", 64'(a.RData), 64'hA);
    chk("pc_2", 64'(a.PC), 64'h2);
    a.RSEL = 2'd2;
    #1;
    chk("rdata_reg2", 64'(a.RData), 64'h5);

    // PC count and wrap
    a.LOAD = 4'hF; a.PC_LOAD = 1'b0; a.PC_Im = 4'hE;
    tick();
    chk("jump_14", 64'(a.PC), 64'hE);
    a.PC_LOAD = 1'b1;
    tick();
    chk("pc_15", 64'({a.PC, a.Wrap}), 64'({4'hF, 1'b0}));
    tick();
    chk("wrap_0", 64'({a.PC, a.Wrap}), 64'({4'h0, 1'b1}));
    tick();
    chk("after_wrap", 64'({a.PC, a.Wrap}), 64'({4'h1, 1'b0}));
    a.PC_LOAD = 1'b0; a.PC_Im = 4'hF;
    tick();
    chk("jump_15", 64'(a.PC), 64'hF);
    a.PC_Im = 4'h0;
    tick();
    chk("jump_to_0_nowrap", 64'({a.PC, a.Wrap}), 64'({4'h0, 1'b0}));

    // Jump with simultaneous load
    a.PC_Im = 4'h5; a.LOAD = 4'b1110; a.Im = 4'h3;
    tick();
    chk("jl_pc", 64'(a.PC), 64'h5);
    chk("jl_regs", 64'(a.Regs), 64'h05A3);

    // Flags
    a.LOAD = 4'hF; a.PC_LOAD = 1'b1;
    a.FLAG_WE = 1'b1; a.Carry = 1'b1; a.Im = 4'h0;
    tick();
    chk("flags_set", 64'({a.CFlag, a.ZFlag}), 64'b11);
    chk("pc_6", 64'(a.PC), 64'h6);
    a.FLAG_WE = 1'b0; a.Carry = 1'b0; a.Im = 4'h7;
    tick();
    chk("flags_hold", 64'({a.CFlag, a.ZFlag}), 64'b11);
    a.FLAG_WE = 1'b1;
    tick();
    chk("flags_clear", 64'({a.CFlag, a.ZFlag}), 64'b00);
    chk("pc_8", 64'(a.PC), 64'h8);

    // EN=0 freezes everything, even at PC all-ones
    a.FLAG_WE = 1'b0; a.PC_LOAD = 1'b0; a.PC_Im = 4'hF;
    tick();
    chk("jump_15b", 64'(a.PC), 64'hF);
    a.EN = 1'b0; a.LOAD = 4'h0; a.Im = 4'hC; a.PC_LOAD = 1'b1;
    a.FLAG_WE = 1'b1; a.Carry = 1'b1;
    tick();
    chk("halt_pc", 64'({a.PC, a.Wrap}), 64'({4'hF, 1'b0}));
    chk("halt_regs", 64'(a.Regs), 64'h05A3);
    chk("halt_flags", 64'({a.CFlag, a.ZFlag}), 64'b00);
    a.EN = 1'b1; a.LOAD = 4'hF; a.FLAG_WE = 1'b0;
    tick();
    chk("resume_wrap", 64'({a.PC, a.Wrap}), 64'({4'h0, 1'b1}));

    // Unknown write data with no strobe low leaves registers intact
    a.Im = 'x;
    tick();
    chk("x_im_regs", 64'(a.Regs), 64'h05A3);
    chk("wrap_one_cycle", 64'(a.Wrap), 64'h0);

    // Wide instance: load reg7, jump to 0x3F, then roll over
    b.EN = 1'b1; b.LOAD = 8'h7F; b.Im = 8'h5C;
    b.PC_LOAD = 1'b0; b.PC_Im = 6'h3F; b.RSEL = 3'd7;
    tick();
    chk("b_pc_3f", 64'(b.PC), 64'h3F);
    chk("b_rdata7", 64'(b.RData), 64'h5C);
    chk("b_regs", b.Regs, 64'h5C00_0000_0000_0000);
    b.LOAD = 8'hFF; b.PC_LOAD = 1'b1;
    tick();
    chk("b_wrap", 64'({b.PC, b.Wrap}), 64'({6'h00, 1'b1}));
    tick();
    chk("b_after_wrap", 64'({b.PC, b.Wrap}), 64'({6'h01, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the TD4-class CPU core: NREG general-purpose registers, a program counter with jump/increment, and registered carry/zero flags, all on one clock with a global enable. It replaces separately instantiated GP, PC and flag registers. It sits between the instruction decoder, which drives the load strobes and enable, and the ALU, which consumes RData, Regs and flags and produces Im and Carry. Unlike earlier flag logic, the flags here are truly clocked state.

## Interface
- WIDTH, 4, data width of each GP register and of Im
- NREG, 4, number of GP registers (≥2; register 0 = A, 1 = B, 2 = OUT port, rest general)
- PC_WIDTH, 4, program counter width (ROM address width)
- RESET_PC, 0, PC value after reset
- SELW, $clog2(NREG), derived, width of RSEL
- CLK  input  1  rising-edge clock
- CLR  input  1  reset, synchronous, active-high
- EN  input  1  global enable; 0 freezes all state (halt / single-step)
- LOAD  input  NREG  per-register load strobe, active-low
- Im  input  WIDTH  write data, from the ALU result
- RSEL  input  SELW  read select for RData
- RData  output  WIDTH  combinational read of register RSEL
- Regs  output  NREG*WIDTH  all registers, flattened; register i at [i*WIDTH +: WIDTH]
- PC_LOAD  input  1  jump strobe, active-low
- PC_Im  input  PC_WIDTH  jump target
- PC  output  PC_WIDTH  program counter
- FLAG_WE  input  1  flag update enable, active-high
- Carry  input  1  ALU carry out
- CFlag  output  1  registered carry flag
- ZFlag  output  1  registered zero flag
- Wrap  output  1  one-cycle pulse: PC rolled over from all-ones to 0 by increment

## Operation
- All state changes only on posedge CLK; priority order: CLR > EN > normal update.
- CLR=1: every GP register = 0, PC = RESET_PC, CFlag = 0, ZFlag = 0, Wrap = 0; overrides EN and all strobes.
- CLR=0, EN=0: registers, PC and flags hold; Wrap forced to 0.
- CLR=0, EN=1:
  - each register i with LOAD[i]=0 takes Im; others hold; several low strobes load the same Im into each.
  - PC: PC_LOAD=0 → PC_Im; else PC+1 modulo 2^PC_WIDTH (increment, never hold while enabled).
  - Wrap = 1 iff PC was all-ones and PC_LOAD=1 (increment wrap); a jump to 0 does not assert it.
  - FLAG_WE=1: CFlag ← Carry, ZFlag ← (Im == 0); FLAG_WE=0: both hold.
- RData = register[RSEL]; RSEL ≥ NREG returns 0.
- No write-through: during a write cycle RData/Regs show the old value; new value is visible after the edge.
- Inputs with X on Im while no LOAD bit is low must not corrupt any register.

## Timing
- Write latency 1 cycle: strobe sampled at edge n, value on Regs/RData after edge n.
- PC, flags and Wrap: registered, 1-cycle latency; Wrap high for exactly one cycle per rollover.
- RData: purely combinational from register state and RSEL, no clock dependency.
- Reset takes effect at the first rising edge with CLR=1, also in mid-operation (e.g. while a jump or load is strobed); the first enabled edge after CLR falls increments PC from RESET_PC.
- Reset values: Regs = 0, RData = 0, PC = RESET_PC, CFlag = 0, ZFlag = 0, Wrap = 0.

## Test plan
- Reset: drive arbitrary state, CLR=1 for one edge with LOAD=all-zero and PC_LOAD=0 → Regs=0, PC=0, CFlag=ZFlag=0, Wrap=0.
- Load/read: LOAD=4'b1101, Im=4'hA, one edge → reg1=A, others unchanged; RSEL=1 → RData=A; during the load edge, RData shows the old value.
- PC count and wrap: EN=1, PC_LOAD=1 from PC=14 → 15, then 0 with Wrap=1 for one cycle, then 1 with Wrap=0; a jump to 0 (PC_Im=0) keeps Wrap=0.
- Jump with simultaneous load: PC_LOAD=0, PC_Im=5, LOAD[0]=0, Im=3 → PC=5 and reg0=3 after the same edge.
- Flags: FLAG_WE=1, Carry=1, Im=0 → CFlag=1, ZFlag=1; FLAG_WE=0, Carry=0, Im=7 → flags hold at 1/1; EN=0 with all strobes active → nothing changes, Wrap=0.
- Parameter sweep: NREG=8, WIDTH=8, PC_WIDTH=6, RESET_PC=6'h20 → reset PC=0x20, wrap at 0x3F→0, RSEL=7 reaches reg7.
